// File: rtl/operand_sequencer.sv
// ---------------------------------------------------------------------------
// operand_sequencer
//
// Purpose:
//   Operand stage in front of the ripple-carry adder. A single switch bus is
//   shared by both operands. The first load press captures operand A together
//   with the carry-in. The second press captures operand B. After the adder has
//   had SETTLE cycles to settle, its {carry, sum} is registered as a stable
//   result for the LEDR display.
//
// Parameters:
//   WIDTH   operand / adder data width
//   SETTLE  cycles from the B capture edge to the result capture edge (>= 1)
//
// Ports:
//   clk         system clock, all state changes on the rising edge
//   reset       synchronous, active-high reset
//   data_in     shared operand bus (switches)
//   cin_in      carry-in request, sampled together with operand A
//   load        load key level; its rising edge is detected internally
//   sum_in      sum returned from the adder
//   cout_in     carry-out returned from the adder
//   a_out       registered operand A driven to the adder
//   b_out       registered operand B driven to the adder
//   c_out       registered carry-in driven to the adder
//   result_out  registered {cout_in, sum_in}
//   valid       high while result_out belongs to the current A/B pair
//   state_out   FSM state: 00 S_A, 01 S_B, 10 S_SETTLE, 11 S_DONE
// ---------------------------------------------------------------------------
module operand_sequencer #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             cin_in,
  input  logic             load,
  input  logic [WIDTH-1:0] sum_in,
  input  logic             cout_in,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic             c_out,
  output logic [WIDTH:0]   result_out,
  output logic             valid,
  output logic [1:0]       state_out
);

  localparam int                CNT_W    = $clog2(SETTLE) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_A      = 2'b00,
    S_B      = 2'b01,
    S_SETTLE = 2'b10,
    S_DONE   = 2'b11
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             c_q, c_d;
  logic [WIDTH:0]   result_q, result_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load_q, load_d;
  logic             rise;

  // A key held down across reset must not count as a press, which is why the
  // edge register comes out of reset as 1 rather than 0.
  assign rise = load & ~load_q;

  // Next-state and datapath logic. Everything holds by default; each state only
  // overrides the registers it is allowed to touch, so operands change solely on
  // their own capture edge.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    result_d = result_q;
    valid_d  = valid_q;
    cnt_d    = cnt_q;
    load_d   = load;

    case (state_q)
      S_A: begin
        if (rise) begin
          a_d     = data_in;
          c_d     = cin_in;
          state_d = S_B;
        end
      end

      S_B: begin
        if (rise) begin
          b_d     = data_in;
          cnt_d   = '0;
          state_d = S_SETTLE;
        end
      end

      // Presses here are dropped on purpose: the operands on the adder must not
      // move while its outputs are still rippling.
      S_SETTLE: begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          result_d = {cout_in, sum_in};
          valid_d  = 1'b1;
          state_d  = S_DONE;
        end
      end

      // A press here starts the next operation by capturing a new A; the old
      // result stays visible but is no longer flagged valid.
      S_DONE: begin
        if (rise) begin
          a_d     = data_in;
          c_d     = cin_in;
          valid_d = 1'b0;
          state_d = S_B;
        end
      end

      default: state_d = S_A;
    endcase
  end

  // State register. Reset has priority over every other event in every state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_A;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= 1'b0;
      result_q <= '0;
      valid_q  <= 1'b0;
      cnt_q    <= '0;
      load_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      cnt_q    <= cnt_d;
      load_q   <= load_d;
    end
  end

  assign a_out      = a_q;
  assign b_out      = b_q;
  assign c_out      = c_q;
  assign result_out = result_q;
  assign valid      = valid_q;
  assign state_out  = state_q;

endmodule

// File: tb/tb_operand_sequencer.sv
// ---------------------------------------------------------------------------
// tb_operand_sequencer
//
// Purpose:
//   Self-checking bench for operand_sequencer with a behavioural 4-bit adder
//   attached to its operand outputs. Directed table vectors, two hand-written
//   multi-cycle sequences and a randomized run compared against a cycle model.
// ---------------------------------------------------------------------------
module tb_operand_sequencer;

  localparam int WIDTH  = 4;
  localparam int SETTLE = 2;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] data_in;
  logic             cin_in;
  logic             load;
  logic [WIDTH-1:0] sum_in;
  logic             cout_in;
  logic [WIDTH-1:0] a_out;
  logic [WIDTH-1:0] b_out;
  logic             c_out;
  logic [WIDTH:0]   result_out;
  logic             valid;
  logic [1:0]       state_out;
  logic [WIDTH:0]   adder_total;

  int checks;
  int errors;

  // Reference model state: a phase number and a countdown of remaining settle
  // cycles, with plain integer arithmetic for the expected sum.
  int m_phase;
  int m_a;
  int m_b;
  int m_c;
  int m_res;
  int m_vld;
  int m_left;
  int m_prev;

  typedef struct {
    logic       rst;
    logic       ld;
    logic [3:0] d;
    logic       ci;
    logic [1:0] st;
    logic [3:0] a;
    logic [3:0] b;
    logic       c;
    logic [4:0] res;
    logic       v;
  } vec_t;

  vec_t tbl[24];

  operand_sequencer #(.WIDTH(WIDTH), .SETTLE(SETTLE)) dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .cin_in     (cin_in),
    .load       (load),
    .sum_in     (sum_in),
    .cout_in    (cout_in),
    .a_out      (a_out),
    .b_out      (b_out),
    .c_out      (c_out),
    .result_out (result_out),
    .valid      (valid),
    .state_out  (state_out)
  );

  // Behavioural ripple-carry adder fed from the sequencer's registered operands.
  assign adder_total = {1'b0, a_out} + {1'b0, b_out} + {4'b0000, c_out};
  assign sum_in      = adder_total[WIDTH-1:0];
  assign cout_in     = adder_total[WIDTH];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic rst, input logic ld, input logic [3:0] d,
                              input logic ci, input logic [1:0] st, input logic [3:0] a,
                              input logic [3:0] b, input logic c, input logic [4:0] res,
                              input logic v);
    vec_t t;
    t.rst = rst; t.ld = ld; t.d = d; t.ci = ci; t.st = st;
    t.a = a; t.b = b; t.c = c; t.res = res; t.v = v;
    return t;
  endfunction

  // Drive one cycle of inputs, let the clock edge happen, then advance the model.
  task automatic applyStimulus(input logic rst, input logic ld, input logic [3:0] d,
                               input logic ci);
    int rise;
    reset   = rst;
    load    = ld;
    data_in = d;
    cin_in  = ci;
    @(posedge clk);
    #1;
    if (rst) begin
      m_phase = 0; m_a = 0; m_b = 0; m_c = 0; m_res = 0; m_vld = 0; m_left = 0;
      m_prev  = 1;
    end else begin
      rise   = (ld && (m_prev == 0)) ? 1 : 0;
      m_prev = ld ? 1 : 0;
      case (m_phase)
        0: if (rise == 1) begin
             m_a = int'(d); m_c = ci ? 1 : 0; m_phase = 1;
           end
        1: if (rise == 1) begin
             m_b = int'(d); m_left = SETTLE; m_phase = 2;
           end
        2: begin
             m_left = m_left - 1;
             if (m_left == 0) begin
               m_res = m_a + m_b + m_c; m_vld = 1; m_phase = 3;
             end
           end
        default: if (rise == 1) begin
             m_a = int'(d); m_c = ci ? 1 : 0; m_vld = 0; m_phase = 1;
           end
      endcase
    end
  endtask

  task automatic checkOutput(input string name, input logic [1:0] st, input logic [3:0] a,
                             input logic [3:0] b, input logic c, input logic [4:0] res,
                             input logic v);
    checks++;
    if (state_out !== st || a_out !== a || b_out !== b || c_out !== c ||
        result_out !== res || valid !== v) begin
      errors++;
      $display("[TB] FAIL %s: got st=%b a=%h b=%h c=%b res=%h v=%b, expected st=%b a=%h b=%h c=%b res=%h v=%b",
               name, state_out, a_out, b_out, c_out, result_out, valid, st, a, b, c, res, v);
    end
  endtask

  task automatic checkModel(input string name);
    checkOutput(name, 2'(m_phase), 4'(m_a), 4'(m_b), 1'(m_c), 5'(m_res), 1'(m_vld));
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset   = 1'b1;
    load    = 1'b0;
    data_in = '0;
    cin_in  = 1'b0;

    //                 rst   ld    d     ci    st     a     b     c     res    v
    tbl[0]  = mk(1'b1, 1'b0, 4'd0, 1'b0, 2'd0, 4'd0, 4'd0, 1'b0, 5'd0,  1'b0);
    tbl[1]  = mk(1'b0, 1'b0, 4'd0, 1'b0, 2'd0, 4'd0, 4'd0, 1'b0, 5'd0,  1'b0);
    tbl[2]  = mk(1'b0, 1'b1, 4'd5, 1'b0, 2'd1, 4'd5, 4'd0, 1'b0, 5'd0,  1'b0);
    tbl[3]  = mk(1'b0, 1'b0, 4'd3, 1'b0, 2'd1, 4'd5, 4'd0, 1'b0, 5'd0,  1'b0);
    tbl[4]  = mk(1'b0, 1'b1, 4'd3, 1'b0, 2'd2, 4'd5, 4'd3, 1'b0, 5'd0,  1'b0);
    tbl[5]  = mk(1'b0, 1'b0, 4'd3, 1'b0, 2'd2, 4'd5, 4'd3, 1'b0, 5'd0,  1'b0);
    tbl[6]  = mk(1'b0, 1'b0, 4'd3, 1'b0, 2'd3, 4'd5, 4'd3, 1'b0, 5'd8,  1'b1);
    tbl[7]  = mk(1'b0, 1'b0, 4'd9, 1'b0, 2'd3, 4'd5, 4'd3, 1'b0, 5'd8,  1'b1);
    tbl[8]  = mk(1'b0, 1'b1, 4'd9, 1'b0, 2'd1, 4'd9, 4'd3, 1'b0, 5'd8,  1'b0);
    tbl[9]  = mk(1'b0, 1'b0, 4'd1, 1'b0, 2'd1, 4'd9, 4'd3, 1'b0, 5'd8,  1'b0);
    tbl[10] = mk(1'b1, 1'b0, 4'd1, 1'b0, 2'd0, 4'd0, 4'd0, 1'b0, 5'd0,  1'b0);
    tbl[11] = mk(1'b0, 1'b0, 4'd1, 1'b0, 2'd0, 4'd0, 4'd0, 1'b0, 5'd0,  1'b0);
    tbl[12] = mk(1'b0, 1'b1, 4'd15,1'b1, 2'd1, 4'd15,4'd0, 1'b1, 5'd0,  1'b0);
    tbl[13] = mk(1'b0, 1'b0, 4'd1, 1'b0, 2'd1, 4'd15,4'd0, 1'b1, 5'd0,  1'b0);
    tbl[14] = mk(1'b0, 1'b1, 4'd1, 1'b0, 2'd2, 4'd15,4'd1, 1'b1, 5'd0,  1'b0);
    tbl[15] = mk(1'b0, 1'b1, 4'd7, 1'b0, 2'd2, 4'd15,4'd1, 1'b1, 5'd0,  1'b0);
    tbl[16] = mk(1'b0, 1'b0, 4'd7, 1'b0, 2'd3, 4'd15,4'd1, 1'b1, 5'd17, 1'b1);
    tbl[17] = mk(1'b0, 1'b1, 4'd2, 1'b0, 2'd1, 4'd2, 4'd1, 1'b0, 5'd17, 1'b0);
    tbl[18] = mk(1'b0, 1'b0, 4'd4, 1'b0, 2'd1, 4'd2, 4'd1, 1'b0, 5'd17, 1'b0);
    tbl[19] = mk(1'b0, 1'b1, 4'd4, 1'b0, 2'd2, 4'd2, 4'd4, 1'b0, 5'd17, 1'b0);
    tbl[20] = mk(1'b0, 1'b0, 4'd6, 1'b0, 2'd2, 4'd2, 4'd4, 1'b0, 5'd17, 1'b0);
    tbl[21] = mk(1'b0, 1'b1, 4'd6, 1'b0, 2'd3, 4'd2, 4'd4, 1'b0, 5'd6,  1'b1);
    tbl[22] = mk(1'b0, 1'b1, 4'd6, 1'b0, 2'd3, 4'd2, 4'd4, 1'b0, 5'd6,  1'b1);
    tbl[23] = mk(1'b0, 1'b0, 4'd6, 1'b0, 2'd3, 4'd2, 4'd4, 1'b0, 5'd6,  1'b1);

    // Directed vectors: 5+3, result hold in S_DONE, new A press, 15+1+1 with
    // overflow, and a press during settle that must be ignored.
    for (int i = 0; i < 24; i++) begin
      applyStimulus(tbl[i].rst, tbl[i].ld, tbl[i].d, tbl[i].ci);
      checkOutput($sformatf("vec%0d", i), tbl[i].st, tbl[i].a, tbl[i].b, tbl[i].c,
                  tbl[i].res, tbl[i].v);
    end

    // Load held high for ten cycles in S_A: one capture only, later data ignored.
    applyStimulus(1'b1, 1'b0, 4'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b0);
    checkOutput("hold_pre", 2'd0, 4'd0, 4'd0, 1'b0, 5'd0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b1, 4'(i + 7), (i == 0) ? 1'b1 : 1'b0);
      checkOutput($sformatf("hold%0d", i), 2'd1, 4'd7, 4'd0, 1'b1, 5'd0, 1'b0);
    end

    // Reset during S_SETTLE with load held high through and after reset.
    applyStimulus(1'b0, 1'b0, 4'd2, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'd2, 1'b0);
    checkOutput("rst_settle_pre", 2'd2, 4'd7, 4'd2, 1'b1, 5'd0, 1'b0);
    applyStimulus(1'b1, 1'b1, 4'd9, 1'b1);
    checkOutput("rst_settle", 2'd0, 4'd0, 4'd0, 1'b0, 5'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 4'd9, 1'b1);
      checkOutput($sformatf("rst_held%0d", i), 2'd0, 4'd0, 4'd0, 1'b0, 5'd0, 1'b0);
    end
    applyStimulus(1'b0, 1'b0, 4'd5, 1'b0);
    checkOutput("rst_drop", 2'd0, 4'd0, 4'd0, 1'b0, 5'd0, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'd5, 1'b0);
    checkOutput("rst_repress", 2'd1, 4'd5, 4'd0, 1'b0, 5'd0, 1'b0);

    // Randomized traffic against the reference model, with occasional resets.
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0,
                    1'($urandom_range(0, 1)),
                    4'($urandom),
                    1'($urandom_range(0, 1)));
      checkModel($sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
